// File: rtl/pc_fetch.sv
// Program counter and byte-wide instruction fetch unit with a jump-load path.
// Optional PC_FETCH_LINK_EN adds a link register that captures the PC on each jump.
module pc_fetch #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             pc_sel,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] pc
`ifdef PC_FETCH_LINK_EN
  ,
  output logic [WIDTH-1:0] link
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             mem_req_q, mem_req_d;
  logic             instr_valid_q, instr_valid_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StReq;
      end
      StReq: begin
        // A jump in the same cycle as the ack discards the returned byte.
        if (!pc_sel && mem_ack) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + WIDTH'(1);
          state_d = StHold;
        end
      end
      StHold: begin
        if (pc_sel || instr_ready) state_d = run ? StReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (pc_sel) pc_d = jump_target;
    // Handshake outputs are registered copies of the next-state decode.
    mem_req_d     = (state_d == StReq);
    instr_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      mem_req_q     <= mem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef PC_FETCH_LINK_EN
  logic [WIDTH-1:0] link_q, link_d;

  always_comb begin
    link_d = link_q;
    if (pc_sel) link_d = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) link_q <= RESET_VECTOR;
    else        link_q <= link_d;
  end

  assign link = link_q;
`endif

  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign mem_req     = mem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus a randomized run against
// a flag-level reference model. Link checks are active when PC_FETCH_LINK_EN is defined.
module tb_pc_fetch;

  logic       clk = 1'b0;
  logic       rst_n, run, pc_sel, mem_ack, instr_ready;
  logic [7:0] jump_target, mem_rdata;
  logic [7:0] mem_addr, instr, pc, link;
  logic       mem_req, instr_valid;
  logic [7:0] mem [256];
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  pc_fetch #(.WIDTH(8), .RESET_VECTOR(8'h10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .jump_target (jump_target),
    .pc_sel      (pc_sel),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc)
`ifdef PC_FETCH_LINK_EN
    ,
    .link        (link)
`endif
  );
`ifndef PC_FETCH_LINK_EN
  assign link = 8'h00;
`endif

  // One rising edge passes; outputs are then sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; pc_sel = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    jump_target = 8'h00; mem_rdata = 8'h00;
    tick(); tick();
    n_chk++; if (pc !== 8'h10) $display("FAIL reset_pc: got %h want 10", pc); else n_pass++;
    n_chk++; if (mem_addr !== 8'h10) $display("FAIL reset_addr: got %h want 10", mem_addr);
    else n_pass++;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req);
    else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid);
    else n_pass++;
    n_chk++; if (instr !== 8'h00) $display("FAIL reset_instr: got %h want 00", instr);
    else n_pass++;
`ifdef PC_FETCH_LINK_EN
    n_chk++; if (link !== 8'h10) $display("FAIL reset_link: got %h want 10", link); else n_pass++;
`endif
    // Enter REQ, then reset asynchronously mid-transfer.
    rst_n = 1'b1; run = 1'b1;
    tick();
    n_chk++; if (mem_req !== 1'b1) $display("FAIL startup_req: got %b want 1", mem_req);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL async_rst_req: got %b want 0", mem_req);
    else n_pass++;
    n_chk++; if (pc !== 8'h10) $display("FAIL async_rst_pc: got %h want 10", pc); else n_pass++;
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (mem_req !== 1'b0) $display("FAIL post_rst_idle: got %b want 0", mem_req);
    else n_pass++;
  endtask

  task automatic test_first_fetch();
    run = 1'b1;
    tick();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h10)
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=10", mem_req, mem_addr);
    else n_pass++;
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    n_chk++; if (instr !== 8'hA5 || instr_valid !== 1'b1 || pc !== 8'h11)
      $display("FAIL first_fetch: got instr=%h v=%b pc=%h want A5 1 11", instr, instr_valid, pc);
    else n_pass++;
    run = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_chk++; if (instr_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL first_idle: got v=%b req=%b want 0 0", instr_valid, mem_req);
    else n_pass++;
  endtask

  task automatic test_stream();
    pc_sel = 1'b1; jump_target = 8'h00;
    tick();
    pc_sel = 1'b0; run = 1'b1; instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'(i))
        $display("FAIL stream_req%0d: got req=%b addr=%h want 1 %h", i, mem_req, mem_addr, 8'(i));
      else n_pass++;
      mem_ack = 1'b1; mem_rdata = mem[i];
      tick();
      mem_ack = 1'b0;
      n_chk++; if (instr_valid !== 1'b1 || instr !== mem[i] || mem_req !== 1'b0)
        $display("FAIL stream_data%0d: got v=%b instr=%h req=%b want 1 %h 0",
                 i, instr_valid, instr, mem_req, mem[i]);
      else n_pass++;
      tick();
    end
    // run drops mid-REQ: transfer still completes into HOLD, then IDLE on accept.
    run = 1'b0; mem_ack = 1'b1; mem_rdata = mem[4];
    tick();
    mem_ack = 1'b0;
    n_chk++; if (instr_valid !== 1'b1 || instr !== mem[4] || pc !== 8'h05)
      $display("FAIL run_drop_req: got v=%b instr=%h pc=%h want 1 %h 05",
               instr_valid, instr, pc, mem[4]);
    else n_pass++;
    tick();
    instr_ready = 1'b0;
    n_chk++; if (instr_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL stream_idle: got v=%b req=%b want 0 0", instr_valid, mem_req);
    else n_pass++;
  endtask

  task automatic test_wrap();
    pc_sel = 1'b1; jump_target = 8'hFF;
    tick();
    pc_sel = 1'b0;
    n_chk++; if (pc !== 8'hFF || mem_req !== 1'b0)
      $display("FAIL idle_jump: got pc=%h req=%b want FF 0", pc, mem_req);
    else n_pass++;
    run = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    n_chk++; if (pc !== 8'h00 || instr !== 8'h5A)
      $display("FAIL wrap_pc: got pc=%h instr=%h want 00 5A", pc, instr);
    else n_pass++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h00)
      $display("FAIL wrap_addr: got req=%b addr=%h want 1 00", mem_req, mem_addr);
    else n_pass++;
    run = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_jump_hold_and_ack();
    pc_sel = 1'b1; jump_target = 8'h30;
    tick();
    pc_sel = 1'b0; run = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    pc_sel = 1'b1; jump_target = 8'h40;
    tick();
    pc_sel = 1'b0;
    n_chk++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h40)
      $display("FAIL jump_hold: got v=%b req=%b addr=%h want 0 1 40",
               instr_valid, mem_req, mem_addr);
    else n_pass++;
`ifdef PC_FETCH_LINK_EN
    n_chk++; if (link !== 8'h31) $display("FAIL jump_hold_link: got %h want 31", link);
    else n_pass++;
`endif
    pc_sel = 1'b1; jump_target = 8'h05;
    tick();
    pc_sel = 1'b0;
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h05)
      $display("FAIL jump_req: got req=%b addr=%h want 1 05", mem_req, mem_addr);
    else n_pass++;
    pc_sel = 1'b1; jump_target = 8'h20; mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    pc_sel = 1'b0;
    n_chk++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h20)
      $display("FAIL jump_ack: got v=%b req=%b addr=%h want 0 1 20",
               instr_valid, mem_req, mem_addr);
    else n_pass++;
`ifdef PC_FETCH_LINK_EN
    n_chk++; if (link !== 8'h05) $display("FAIL jump_ack_link: got %h want 05", link);
    else n_pass++;
`endif
    mem_rdata = 8'h88;
    tick();
    mem_ack = 1'b0;
    n_chk++; if (instr_valid !== 1'b1 || instr !== 8'h88 || pc !== 8'h21)
      $display("FAIL refetch: got v=%b instr=%h pc=%h want 1 88 21", instr_valid, instr, pc);
    else n_pass++;
  endtask

  task automatic test_stall_run_drop();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) run = 1'b0;
      tick();
      n_chk++; if (instr_valid !== 1'b1 || instr !== 8'h88 || mem_req !== 1'b0)
        $display("FAIL stall%0d: got v=%b instr=%h req=%b want 1 88 0",
                 c, instr_valid, instr, mem_req);
      else n_pass++;
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (instr_valid !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL parked%0d: got v=%b req=%b want 0 0", c, instr_valid, mem_req);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [7:0] m_pc, m_instr, m_link;
    logic       m_req, m_valid;
    int         n_bytes = 0;
    rst_n = 1'b0; run = 1'b0; pc_sel = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    m_pc = 8'h10; m_instr = 8'h00; m_link = 8'h10; m_req = 1'b0; m_valid = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_chk++; if (mem_req !== m_req || mem_addr !== m_pc || pc !== m_pc ||
                   instr_valid !== m_valid || (m_valid && instr !== m_instr))
        $display("FAIL rand%0d: got req=%b addr=%h pc=%h v=%b instr=%h want %b %h %h %b %h",
                 cyc, mem_req, mem_addr, pc, instr_valid, instr,
                 m_req, m_pc, m_pc, m_valid, m_instr);
      else n_pass++;
`ifdef PC_FETCH_LINK_EN
      n_chk++; if (link !== m_link)
        $display("FAIL rand_link%0d: got %h want %h", cyc, link, m_link);
      else n_pass++;
`endif
      run         = ($urandom_range(9) != 0);
      pc_sel      = ($urandom_range(9) == 0);
      jump_target = 8'($urandom);
      mem_ack     = m_req && ($urandom_range(2) != 0);
      mem_rdata   = 8'($urandom);
      instr_ready = ($urandom_range(1) == 1);
      // Model: effect of these inputs at the coming edge.
      if (pc_sel) begin
        m_link = m_pc;
        if (m_valid) begin
          m_valid = 1'b0;
          m_req   = run;
        end else if (!m_req) begin
          m_req = run;
        end
        m_pc = jump_target;
      end else if (m_req) begin
        if (mem_ack) begin
          m_instr = mem_rdata;
          m_pc    = m_pc + 8'd1;
          m_req   = 1'b0;
          m_valid = 1'b1;
          n_bytes++;
        end
      end else if (m_valid) begin
        if (instr_ready) begin
          m_valid = 1'b0;
          m_req   = run;
        end
      end else begin
        m_req = run;
      end
      tick();
    end
    n_chk++; if (n_bytes < 50) $display("FAIL rand_activity: got %0d bytes want >=50", n_bytes);
    else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    test_reset();
    test_first_fetch();
    test_stream();
    test_wrap();
    test_jump_hold_and_ack();
    test_stall_run_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
